// File: rtl/tpu_ctrl_pkg.sv
// Shared types for the tpuv1 command sequencer: opcodes, error codes, FSM states
// and default matrix geometry.
package tpu_ctrl_pkg;
  localparam int TPU_DIM   = 32;
  localparam int TPU_IDX_W = $clog2(TPU_DIM);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_WR_A  = 3'd1,
    OP_WR_B  = 3'd2,
    OP_WR_C  = 3'd3,
    OP_START = 3'd4,
    OP_RD_C  = 3'd5,
    OP_CLR   = 3'd6
  } cmd_op_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LOAD = 2'd1,
    ERR_WDOG = 2'd2,
    ERR_OP   = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_READ    = 3'd3,
    ST_RESP    = 3'd4
  } state_e;
endpackage

// File: rtl/tpu_ctrl_ldmask.sv
// Per-row operand load tracker: one bit per matrix row, set on write, bulk clear,
// full_o once every row has been written.
module tpu_ctrl_ldmask
  import tpu_ctrl_pkg::*;
#(
  parameter int DIM   = TPU_DIM,
  parameter int IDX_W = TPU_IDX_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             clr_i,
  output logic             full_o
);
  logic [DIM-1:0] mask_q;

  // Clear wins; the top never issues both in the same cycle anyway.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      mask_q <= '0;
    else if (clr_i) mask_q <= '0;
    else if (set_i) mask_q[idx_i] <= 1'b1;
  end

  assign full_o = &mask_q;
endmodule

// File: rtl/tpu_ctrl.sv
// Command sequencer for the tpuv1 systolic unit. Optional compute watchdog is
// compiled in with TPU_CTRL_WDOG_EN.
module tpu_ctrl
  import tpu_ctrl_pkg::*;
#(
  parameter int  DIM         = TPU_DIM,
  parameter int  DATA_W      = 32,
  parameter int  WDOG_CYCLES = 1024,
  localparam int IDX_W       = $clog2(DIM)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [IDX_W-1:0]  cmd_row_i,
  input  logic [IDX_W-1:0]  cmd_col_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              tpu_start_o,
  output logic              tpu_wr_en_a_o,
  output logic              tpu_wr_en_b_o,
  output logic              tpu_wr_en_c_o,
  output logic [IDX_W-1:0]  tpu_row_o,
  output logic [IDX_W-1:0]  tpu_col_o,
  output logic [DATA_W-1:0] tpu_data_o,
  input  logic [DATA_W-1:0] tpu_data_i,
  input  logic              tpu_done_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              busy_o,
  output logic [1:0]        err_o
);
  state_e              state_q;
  cmd_op_e             op_q;
  err_e                err_q;
  logic                ready_q;
  logic [IDX_W-1:0]    row_q, col_q;
  logic [DATA_W-1:0]   data_q, rsp_q;
  logic                accept, a_full, b_full, start_ok, mask_clr, wdog_exp;

  assign accept   = cmd_valid_i && ready_q;
  assign start_ok = a_full && b_full;
  assign mask_clr = accept && ((cmd_op_i == OP_CLR) || ((cmd_op_i == OP_START) && start_ok));

  tpu_ctrl_ldmask #(.DIM(DIM), .IDX_W(IDX_W)) u_mask_a (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .set_i  (accept && (cmd_op_i == OP_WR_A)),
    .idx_i  (cmd_row_i),
    .clr_i  (mask_clr),
    .full_o (a_full)
  );

  tpu_ctrl_ldmask #(.DIM(DIM), .IDX_W(IDX_W)) u_mask_b (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .set_i  (accept && (cmd_op_i == OP_WR_B)),
    .idx_i  (cmd_row_i),
    .clr_i  (mask_clr),
    .full_o (b_full)
  );

`ifdef TPU_CTRL_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q;

  // Zero outside COMPUTE, so it is cleared on every COMPUTE entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      wdog_q <= '0;
    else if (state_q != ST_COMPUTE) wdog_q <= '0;
    else                            wdog_q <= wdog_q + 1'b1;
  end

  assign wdog_exp = (wdog_q == WDOG_W'(WDOG_CYCLES - 1));
`else
  assign wdog_exp = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      op_q    <= OP_NOP;
      err_q   <= ERR_NONE;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          row_q  <= cmd_row_i;
          col_q  <= cmd_col_i;
          data_q <= cmd_data_i;
          op_q   <= cmd_op_e'(cmd_op_i);
          err_q  <= ERR_NONE;
          case (cmd_op_i)
            OP_WR_A, OP_WR_B, OP_WR_C: begin
              state_q <= ST_WRITE;
              ready_q <= 1'b0;
            end
            OP_START: if (start_ok) begin
              state_q <= ST_COMPUTE;
              ready_q <= 1'b0;
            end else begin
              err_q <= ERR_LOAD;
            end
            OP_RD_C: begin
              state_q <= ST_READ;
              ready_q <= 1'b0;
            end
            OP_NOP, OP_CLR: ;
            default: err_q <= ERR_OP;
          endcase
        end
        ST_WRITE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        // The unit cannot be aborted, so flush is ignored while computing.
        ST_COMPUTE: if (tpu_done_i) begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end else if (wdog_exp) begin
          err_q   <= ERR_WDOG;
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        ST_READ: if (flush_i) begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end else begin
          rsp_q   <= tpu_data_i;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready_o   = ready_q;
  assign busy_o        = ~ready_q;
  assign err_o         = err_q;
  assign tpu_start_o   = (state_q == ST_COMPUTE);
  assign tpu_wr_en_a_o = (state_q == ST_WRITE) && (op_q == OP_WR_A);
  assign tpu_wr_en_b_o = (state_q == ST_WRITE) && (op_q == OP_WR_B);
  assign tpu_wr_en_c_o = (state_q == ST_WRITE) && (op_q == OP_WR_C);
  assign tpu_row_o     = row_q;
  assign tpu_col_o     = col_q;
  assign tpu_data_o    = data_q;
  // A flush arriving in the response cycle still kills the pulse.
  assign rsp_valid_o   = (state_q == ST_RESP) && !flush_i;
  assign rsp_data_o    = rsp_q;
endmodule

// File: tb/tb_tpu_ctrl.sv
// Self-checking bench for tpu_ctrl: random stimulus against a command-level
// reference model (load masks, C matrix contents, error codes, latencies).
module tb_tpu_ctrl;
  localparam int DIM   = 32;
  localparam int IDX_W = 5;
  localparam int WDOG  = 16;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic [2:0]       cmd_op_i = '0;
  logic [IDX_W-1:0] cmd_row_i = '0, cmd_col_i = '0;
  logic [31:0]      cmd_data_i = '0;
  logic             tpu_start_o, tpu_wr_en_a_o, tpu_wr_en_b_o, tpu_wr_en_c_o;
  logic [IDX_W-1:0] tpu_row_o, tpu_col_o;
  logic [31:0]      tpu_data_o, tpu_data_i;
  logic             tpu_done_i = 1'b0;
  logic             rsp_valid_o;
  logic [31:0]      rsp_data_o;
  logic             busy_o;
  logic [1:0]       err_o;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference state
  logic [DIM-1:0] a_ref, b_ref;
  logic [31:0]    cref [DIM*DIM];
  // Behavioural model of the unit's C storage
  logic [31:0]    umem [DIM*DIM];

  tpu_ctrl #(.DIM(DIM), .DATA_W(32), .WDOG_CYCLES(WDOG)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_row_i(cmd_row_i), .cmd_col_i(cmd_col_i), .cmd_data_i(cmd_data_i),
    .tpu_start_o(tpu_start_o), .tpu_wr_en_a_o(tpu_wr_en_a_o), .tpu_wr_en_b_o(tpu_wr_en_b_o),
    .tpu_wr_en_c_o(tpu_wr_en_c_o), .tpu_row_o(tpu_row_o), .tpu_col_o(tpu_col_o),
    .tpu_data_o(tpu_data_o), .tpu_data_i(tpu_data_i), .tpu_done_i(tpu_done_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  always @(posedge clk_i) if (tpu_wr_en_c_o) umem[{tpu_row_o, tpu_col_o}] <= tpu_data_o;
  assign tpu_data_i = umem[{tpu_row_o, tpu_col_o}];

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic issue(input logic [2:0] op, input int row, input int col, input logic [31:0] d);
    cmd_valid_i = 1'b1; cmd_op_i = op;
    cmd_row_i = IDX_W'(row); cmd_col_i = IDX_W'(col); cmd_data_i = d;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  // Command-level model: masks, C contents, resulting error code.
  task automatic model_cmd(input logic [2:0] op, input int row, input int col,
                           input logic [31:0] d, output logic [1:0] err);
    err = 2'd0;
    case (op)
      3'd1: a_ref[row] = 1'b1;
      3'd2: b_ref[row] = 1'b1;
      3'd3: cref[row*DIM+col] = d;
      3'd4: if (&a_ref && &b_ref) begin a_ref = '0; b_ref = '0; end else err = 2'd1;
      3'd6: begin a_ref = '0; b_ref = '0; end
      3'd7: err = 2'd3;
      default: ;
    endcase
  endtask

  // Cycles from acceptance until ready is back (non-START commands).
  function automatic int lat(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2 || op == 3'd3) return 2;
    if (op == 3'd5) return 3;
    return 1;
  endfunction

  task automatic do_cmd(input logic [2:0] op, input int row, input int col, input logic [31:0] d);
    logic [1:0] e;
    model_cmd(op, row, col, d, e);
    issue(op, row, col, d);
    repeat (lat(op) - 1) tick();
  endtask

  task automatic fill_masks(input int skip);
    do_cmd(3'd6, 0, 0, 32'h0);
    for (int i = 0; i < DIM; i++)
      if (i != skip) do_cmd(3'd1, i, $urandom_range(0, DIM-1), $urandom);
    for (int i = 0; i < DIM; i++)
      do_cmd(3'd2, i, $urandom_range(0, DIM-1), $urandom);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    n_chk++;
    if ({cmd_ready_o, busy_o, tpu_start_o, tpu_wr_en_a_o, tpu_wr_en_b_o, tpu_wr_en_c_o, rsp_valid_o} !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 1000000",
        {cmd_ready_o, busy_o, tpu_start_o, tpu_wr_en_a_o, tpu_wr_en_b_o, tpu_wr_en_c_o, rsp_valid_o});
    end
    n_chk++;
    if ({err_o, rsp_data_o, tpu_data_o, tpu_row_o, tpu_col_o} !== '0) begin
      n_fail++; $display("FAIL reset_data: err=%0d rsp=%h data=%h row=%0d col=%0d want all 0",
        err_o, rsp_data_o, tpu_data_o, tpu_row_o, tpu_col_o);
    end
    tick();
  endtask

  task automatic test_write();
    logic [1:0] e;
    model_cmd(3'd1, 3, 7, 32'h0001_0002, e);
    issue(3'd1, 3, 7, 32'h0001_0002);
    @(negedge clk_i);
    n_chk++;
    if ({cmd_ready_o, busy_o, tpu_wr_en_a_o, tpu_wr_en_b_o, tpu_wr_en_c_o} !== 5'b01100) begin
      n_fail++; $display("FAIL wr_a_ctrl: got %b want 01100",
        {cmd_ready_o, busy_o, tpu_wr_en_a_o, tpu_wr_en_b_o, tpu_wr_en_c_o});
    end
    n_chk++;
    if (tpu_row_o !== 5'd3 || tpu_col_o !== 5'd7 || tpu_data_o !== 32'h0001_0002) begin
      n_fail++; $display("FAIL wr_a_addr: got row=%0d col=%0d data=%h want 3 7 00010002",
        tpu_row_o, tpu_col_o, tpu_data_o);
    end
    @(negedge clk_i);
    n_chk++;
    if ({cmd_ready_o, tpu_wr_en_a_o, err_o} !== 4'b1000 || tpu_data_o !== 32'h0001_0002) begin
      n_fail++; $display("FAIL wr_a_done: ready=%b wr_a=%b err=%0d data=%h want 1 0 0 00010002",
        cmd_ready_o, tpu_wr_en_a_o, err_o, tpu_data_o);
    end
    // Random writes; a flush during WRITE must not cancel the write.
    for (int k = 0; k < 8; k++) begin
      logic [2:0] op;
      int r, c;
      logic [31:0] d;
      op = 3'($urandom_range(1, 3)); r = $urandom_range(0, DIM-1);
      c = $urandom_range(0, DIM-1); d = $urandom;
      model_cmd(op, r, c, d, e);
      issue(op, r, c, d);
      flush_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      n_chk++;
      if ({tpu_wr_en_a_o, tpu_wr_en_b_o, tpu_wr_en_c_o} !== {op == 3'd1, op == 3'd2, op == 3'd3}
          || tpu_row_o !== IDX_W'(r) || tpu_col_o !== IDX_W'(c) || tpu_data_o !== d) begin
        n_fail++; $display("FAIL wr_rand op=%0d: en=%b row=%0d col=%0d data=%h want row=%0d col=%0d data=%h",
          op, {tpu_wr_en_a_o, tpu_wr_en_b_o, tpu_wr_en_c_o}, tpu_row_o, tpu_col_o, tpu_data_o, r, c, d);
      end
      tick();
      flush_i = 1'b0;
    end
  endtask

  task automatic test_load_start();
    logic [1:0] e;
    int m, cnt;
    m = $urandom_range(0, DIM-1);
    fill_masks(m);
    model_cmd(3'd4, 0, 0, 32'h0, e);
    issue(3'd4, 0, 0, 32'h0);
    @(negedge clk_i);
    n_chk++;
    if (err_o !== e || tpu_start_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL start_incomplete: err=%0d start=%b ready=%b want err=%0d start=0 ready=1",
        err_o, tpu_start_o, cmd_ready_o, e);
    end
    do_cmd(3'd1, m, 0, $urandom);
    @(negedge clk_i);
    n_chk++;
    if (err_o !== 2'd0) begin
      n_fail++; $display("FAIL err_overwrite: got %0d want 0", err_o);
    end
    model_cmd(3'd4, 0, 0, 32'h0, e);
    issue(3'd4, 0, 0, 32'h0);
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      tpu_done_i = (c == 40);
      flush_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      if (!busy_o) break;
      cnt++;
      n_chk++;
      if (tpu_start_o !== 1'b1) begin
        n_fail++; $display("FAIL start_held c=%0d: got %b want 1", c, tpu_start_o);
      end
      tick();
    end
    tpu_done_i = 1'b0; flush_i = 1'b0;
    n_chk++;
    if (cnt !== 41 || tpu_start_o !== 1'b0 || cmd_ready_o !== 1'b1 || err_o !== e) begin
      n_fail++; $display("FAIL compute_len: busy=%0d start=%b ready=%b err=%0d want 41 0 1 %0d",
        cnt, tpu_start_o, cmd_ready_o, err_o, e);
    end
    model_cmd(3'd4, 0, 0, 32'h0, e);
    issue(3'd4, 0, 0, 32'h0);
    @(negedge clk_i);
    n_chk++;
    if (err_o !== e || e !== 2'd1 || tpu_start_o !== 1'b0) begin
      n_fail++; $display("FAIL masks_cleared: err=%0d start=%b want err=1 start=0", err_o, tpu_start_o);
    end
  endtask

  task automatic test_read();
    do_cmd(3'd3, 5, 9, 32'hDEAD_BEEF);
    issue(3'd5, 5, 9, 32'h0);
    @(negedge clk_i);
    n_chk++;
    if (rsp_valid_o !== 1'b0 || tpu_row_o !== 5'd5 || tpu_col_o !== 5'd9 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL rd_addr: vld=%b row=%0d col=%0d busy=%b want 0 5 9 1",
        rsp_valid_o, tpu_row_o, tpu_col_o, busy_o);
    end
    @(negedge clk_i);
    n_chk++;
    if (rsp_valid_o !== 1'b1 || rsp_data_o !== cref[5*DIM+9]) begin
      n_fail++; $display("FAIL rd_rsp: vld=%b data=%h want 1 %h", rsp_valid_o, rsp_data_o, cref[5*DIM+9]);
    end
    @(negedge clk_i);
    n_chk++;
    if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL rd_done: vld=%b ready=%b want 0 1", rsp_valid_o, cmd_ready_o);
    end
    tick();
    // Flush during READ: no response, straight back to idle.
    issue(3'd5, 5, 9, 32'h0);
    flush_i = 1'b1;
    @(negedge clk_i);
    n_chk++;
    if (rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rd_flush_read: vld=%b want 0", rsp_valid_o);
    end
    tick();
    flush_i = 1'b0;
    @(negedge clk_i);
    n_chk++;
    if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL rd_flush_idle: vld=%b ready=%b want 0 1", rsp_valid_o, cmd_ready_o);
    end
    tick();
    // Flush during RESP: pulse suppressed.
    issue(3'd5, 5, 9, 32'h0);
    tick();
    flush_i = 1'b1;
    @(negedge clk_i);
    n_chk++;
    if (rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rd_flush_resp: vld=%b want 0", rsp_valid_o);
    end
    tick();
    flush_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      int r, c;
      r = $urandom_range(0, DIM-1); c = $urandom_range(0, DIM-1);
      do_cmd(3'd3, r, c, $urandom);
      issue(3'd5, r, c, 32'h0);
      tick();
      @(negedge clk_i);
      n_chk++;
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== cref[r*DIM+c]) begin
        n_fail++; $display("FAIL rd_rand (%0d,%0d): vld=%b data=%h want 1 %h",
          r, c, rsp_valid_o, rsp_data_o, cref[r*DIM+c]);
      end
      tick();
    end
  endtask

  task automatic test_wdog();
    logic [1:0] e;
    int cnt;
    fill_masks(-1);
    model_cmd(3'd4, 0, 0, 32'h0, e);
    issue(3'd4, 0, 0, 32'h0);
`ifdef TPU_CTRL_WDOG_EN
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      flush_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      if (!busy_o) break;
      cnt++;
      tick();
    end
    flush_i = 1'b0;
    n_chk++;
    if (cnt !== WDOG || err_o !== 2'd2 || tpu_start_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL wdog: busy=%0d err=%0d start=%b ready=%b want %0d 2 0 1",
        cnt, err_o, tpu_start_o, cmd_ready_o, WDOG);
    end
`else
    cnt = 0;
    repeat (1000) tick();
    @(negedge clk_i);
    n_chk++;
    if (busy_o !== 1'b1 || tpu_start_o !== 1'b1 || err_o !== 2'd0) begin
      n_fail++; $display("FAIL no_wdog: busy=%b start=%b err=%0d want 1 1 0", busy_o, tpu_start_o, err_o);
    end
    tick();
    tpu_done_i = 1'b1;
    tick();
    tpu_done_i = 1'b0;
    @(negedge clk_i);
    n_chk++;
    if (cmd_ready_o !== 1'b1 || tpu_start_o !== 1'b0 || err_o !== e) begin
      n_fail++; $display("FAIL no_wdog_done: ready=%b start=%b err=%0d want 1 0 %0d",
        cmd_ready_o, tpu_start_o, err_o, e);
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid_compute();
    logic [1:0] e;
    fill_masks(-1);
    model_cmd(3'd4, 0, 0, 32'h0, e);
    issue(3'd4, 0, 0, 32'h0);
    repeat (4) tick();
    n_chk++;
    if (tpu_start_o !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_start: got %b want 1", tpu_start_o);
    end
    rst_i = 1'b1;
    a_ref = '0; b_ref = '0;
    #2;
    n_chk++;
    if ({tpu_start_o, cmd_ready_o, busy_o, err_o} !== 5'b01000) begin
      n_fail++; $display("FAIL reset_mid: start=%b ready=%b busy=%b err=%0d want 0 1 0 0",
        tpu_start_o, cmd_ready_o, busy_o, err_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    model_cmd(3'd4, 0, 0, 32'h0, e);
    issue(3'd4, 0, 0, 32'h0);
    @(negedge clk_i);
    n_chk++;
    if (err_o !== e || e !== 2'd1 || tpu_start_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_masks: err=%0d start=%b want 1 0", err_o, tpu_start_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [3];
    int          rows [3], cols [3], acc [3];
    logic [1:0]  e;
    logic [31:0] exp_rsp;
    int          k, nrsp;
    logic [31:0] got_rsp;
    do_cmd(3'd6, 0, 0, 32'h0);
    ops[0] = 3'd2; rows[0] = $urandom_range(0, DIM-1); cols[0] = 0;
    ops[1] = 3'd5; rows[1] = 5; cols[1] = 9;
    ops[2] = 3'd7; rows[2] = 0; cols[2] = 0;
    exp_rsp = cref[5*DIM+9];
    k = 0; nrsp = 0; got_rsp = '0;
    cmd_valid_i = 1'b1; cmd_op_i = ops[0];
    cmd_row_i = IDX_W'(rows[0]); cmd_col_i = IDX_W'(cols[0]); cmd_data_i = $urandom;
    for (int c = 0; c < 50 && k < 3; c++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin nrsp++; got_rsp = rsp_data_o; end
      if (cmd_ready_o) begin
        acc[k] = cyc;
        model_cmd(ops[k], rows[k], cols[k], cmd_data_i, e);
        tick();
        k++;
        if (k < 3) begin
          cmd_op_i = ops[k]; cmd_row_i = IDX_W'(rows[k]); cmd_col_i = IDX_W'(cols[k]);
        end else cmd_valid_i = 1'b0;
      end else tick();
    end
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    n_chk++;
    if (k !== 3 || acc[1] - acc[0] !== lat(ops[0]) || acc[2] - acc[1] !== lat(ops[1])) begin
      n_fail++; $display("FAIL b2b_accept: accepted=%0d gaps=%0d,%0d want 3 %0d,%0d",
        k, acc[1] - acc[0], acc[2] - acc[1], lat(ops[0]), lat(ops[1]));
    end
    n_chk++;
    if (err_o !== e || e !== 2'd3 || cmd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_err: err=%0d ready=%b want 3 1", err_o, cmd_ready_o);
    end
    n_chk++;
    if (nrsp !== 1 || got_rsp !== exp_rsp) begin
      n_fail++; $display("FAIL b2b_rsp: pulses=%0d data=%h want 1 %h", nrsp, got_rsp, exp_rsp);
    end
    tick();
  endtask

  initial begin
    a_ref = '0; b_ref = '0;
    for (int i = 0; i < DIM*DIM; i++) cref[i] = '0;
    test_reset();
    test_write();
    test_load_start();
    test_read();
    test_wdog();
    test_reset_mid_compute();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tpu_ctrl.md
# tpu_ctrl

Command sequencer for the execute-stage systolic matrix unit (`tpuv1`, BITS_AB=16, BITS_C=32, DIM=32). It accepts one matrix command at a time from the execute stage and drives the unit's write enables, row/col, data and start lines. It waits for compute completion, returns C-element reads as a single-cycle response, and raises a busy/stall request to the pipeline while a command is in flight. It also tracks which A/B rows have been loaded and rejects a START issued before both operands are complete.

## Interface
- DIM, 32, matrix dimension; index width IDX_W = $clog2(DIM)
- DATA_W, 32, data path width
- WDOG_CYCLES, 1024, compute timeout in cycles (used only with watchdog compiled in)
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  pipeline flush; discards a pending read response
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  controller can accept a command
- cmd_op_i  in  3  opcode: NOP=0, WR_A=1, WR_B=2, WR_C=3, START=4, RD_C=5, CLR=6
- cmd_row_i, cmd_col_i  in  IDX_W each  element address
- cmd_data_i  in  DATA_W  write data
- tpu_start_o, tpu_wr_en_a_o, tpu_wr_en_b_o, tpu_wr_en_c_o  out  1 each  unit controls
- tpu_row_o, tpu_col_o  out  IDX_W each  unit address
- tpu_data_o  out  DATA_W  unit dataIn
- tpu_data_i  in  DATA_W  unit dataOut
- tpu_done_i  in  1  unit done
- rsp_valid_o  out  1  one-cycle pulse that qualifies rsp_data_o
- rsp_data_o  out  DATA_W  RD_C result
- busy_o  out  1  stall request to the pipeline; equals !cmd_ready_o
- err_o  out  2  0 none, 1 START with incomplete load, 2 compute timeout, 3 illegal opcode

## Operation
- FSM states:
  - IDLE: cmd_ready_o=1.
  - WRITE: one cycle; drives the selected tpu_wr_en_*_o, row, col and data, then returns to IDLE.
  - COMPUTE: tpu_start_o held high until tpu_done_i is sampled high, then IDLE.
  - READ: row/col driven for one cycle, then RESP.
  - RESP: captures tpu_data_i and pulses rsp_valid_o, then IDLE.
- A command is accepted on cmd_valid_i && cmd_ready_o. Row, col and data are registered at acceptance.
- Per-row load masks a_mask, b_mask (DIM bits each):
  - WR_A / WR_B sets bit cmd_row_i in the corresponding mask.
  - CLR zeroes both masks, with no unit activity.
  - A successful START zeroes both masks.
- START with a_mask or b_mask not all-ones: err_o=1, no unit activity, stays in IDLE.
- NOP: accepted, no effect. Opcode 7: err_o=3, otherwise ignored.
- err_o holds its value until the next accepted command, which overwrites it (to 0 if that command succeeds).
- flush_i in READ or RESP: the response is suppressed (rsp_valid_o stays 0) and the FSM returns to IDLE.
- flush_i in COMPUTE does not abort the unit, which cannot be stopped. The FSM keeps waiting for done; no other effect.
- flush_i in IDLE/WRITE: no effect; a write already accepted completes.
- All unit controls are 0 whenever not in their active state. tpu_data_o, row and col hold their last value.

## Timing
- Reset: state=IDLE; all outputs 0 except cmd_ready_o=1; masks 0. Reset mid-COMPUTE returns to IDLE immediately; the unit is expected to share the reset.
- WR_*: accepted at cycle N, write enable high in cycle N+1, cmd_ready_o high again in N+2. Throughput is one write per 2 cycles.
- RD_C: accepted at N, row/col on the unit from N+1, rsp_valid_o high in N+2 with the data sampled at the end of N+1, ready in N+3.
- START: accepted at N, tpu_start_o high from N+1. If tpu_done_i is high in cycle M, tpu_start_o=0 and cmd_ready_o=1 in M+1. If done is already high in N+1, COMPUTE lasts exactly one cycle.
- cmd_ready_o and busy_o are registered and change only on the clock edge.

## Configuration
- TPU_CTRL_WDOG_EN defined:
  - A counter clears on COMPUTE entry and increments each COMPUTE cycle.
  - When it reaches WDOG_CYCLES without done: err_o=2, tpu_start_o dropped, return to IDLE.
- TPU_CTRL_WDOG_EN undefined: no counter; COMPUTE waits indefinitely; err_o never takes value 2.

## Structure
- Shared package tpu_ctrl_pkg holds:
  - the cmd_op enum;
  - the err code enum;
  - the FSM state enum;
  - DIM and IDX_W defaults.
- Sub-module tpu_ctrl_ldmask: a DIM-bit set/clear mask with an all-ones flag, instantiated twice (A and B).

## Test plan
- Reset asserted mid-COMPUTE -> next cycle tpu_start_o=0, cmd_ready_o=1, masks=0, err_o=0.
- WR_A row=3 col=7 data=0x0001_0002 -> tpu_wr_en_a_o=1 one cycle with row=3, col=7, tpu_data_o=0x0001_0002; ready returns 2 cycles after acceptance.
- 31 WR_A rows plus 32 WR_B rows, then START -> err_o=1, tpu_start_o stays 0. Write the missing A row, then START -> tpu_start_o high until done. Done held low for 40 cycles yields 40+1 busy cycles; masks cleared afterwards.
- RD_C row=5 col=9 with the model returning 0xDEAD_BEEF -> rsp_valid_o one cycle, rsp_data_o=0xDEAD_BEEF. The same read with flush_i in the READ cycle -> no rsp_valid_o.
- With TPU_CTRL_WDOG_EN and WDOG_CYCLES=16, done never asserted -> after 16 COMPUTE cycles err_o=2 and IDLE. Without the macro -> still busy after 1000 cycles.
- Back-to-back cmd_valid_i held high with WR_B, RD_C, opcode 7 -> each accepted only while ready; the opcode-7 command sets err_o=3.
